// File: rtl/uart_tx_drain_if.sv
// rtl/uart_tx_drain_if.sv - FIFO-side and UART-side signal bundle for uart_tx_drain
//
// Purpose: groups the FIFO read handshake and the UART line/status outputs.
// Signals:
//   i_Enable             - permits starting a new frame
//   i_Fifo_Byte[7:0]     - FIFO head byte
//   i_Fifo_Ready_To_Read - FIFO holds at least one byte
//   o_Fifo_Shift         - one-cycle pop pulse to the FIFO
//   o_Tx_Serial          - UART line, idles high
//   o_Tx_Active          - high while a frame is on the line
//   o_Tx_Done            - one-cycle pulse after the stop bit
// Modports: slave = the drain block, master = whoever drives the FIFO side.
interface uart_tx_drain_if;
    logic       i_Enable;
    logic [7:0] i_Fifo_Byte;
    logic       i_Fifo_Ready_To_Read;
    logic       o_Fifo_Shift;
    logic       o_Tx_Serial;
    logic       o_Tx_Active;
    logic       o_Tx_Done;

    modport slave (
        input  i_Enable,
        input  i_Fifo_Byte,
        input  i_Fifo_Ready_To_Read,
        output o_Fifo_Shift,
        output o_Tx_Serial,
        output o_Tx_Active,
        output o_Tx_Done
    );

    modport master (
        output i_Enable,
        output i_Fifo_Byte,
        output i_Fifo_Ready_To_Read,
        input  o_Fifo_Shift,
        input  o_Tx_Serial,
        input  o_Tx_Active,
        input  o_Tx_Done
    );
endinterface

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - drains a byte FIFO onto a UART 8N1 transmit line
//
// Purpose: when enabled and idle with data available, pops the FIFO head byte
// (one-cycle o_Fifo_Shift) and serialises it as start, 8 data bits LSB first,
// stop, each bit CLKS_PER_BIT clocks long. All outputs are registered.
// Ports:
//   i_Clk   - system clock, rising edge
//   i_Rst_L - synchronous active-low reset
//   bus     - uart_tx_drain_if.slave (enable, FIFO head/ready/shift, line, status)
// Parameters:
//   CLKS_PER_BIT - clocks per UART bit, 2..65535
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    uart_tx_drain_if.slave   bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q,   shreg_d;
    logic          serial_q,  serial_d;
    logic          shift_q,   shift_d;
    logic          active_q,  active_d;
    logic          done_q,    done_d;

    logic bit_end;
    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            serial_q  <= 1'b1;
            shift_q   <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            serial_q  <= serial_d;
            shift_q   <= shift_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // The next line value is registered at each bit boundary, so the line
    // changes exactly on the edge where the previous bit period expires.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        serial_d  = serial_q;
        shift_d   = 1'b0;
        active_d  = active_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_Enable && bus.i_Fifo_Ready_To_Read) begin
                    shreg_d  = bus.i_Fifo_Byte;
                    shift_d  = 1'b1;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // Shift register moves right so bit 0 is always the next one out.
                    serial_d  = shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_Fifo_Shift = shift_q;
    assign bus.o_Tx_Serial  = serial_q;
    assign bus.o_Tx_Active  = active_q;
    assign bus.o_Tx_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - self-checking bench for uart_tx_drain
module tb_uart_tx_drain;

    logic       clk;
    logic       rst_l;
    logic       tb_en;
    logic [7:0] fifo_byte;
    logic       fifo_ready;
    int         sel;

    uart_tx_drain_if if4 ();
    uart_tx_drain_if if2 ();
    uart_tx_drain_if if217 ();

    assign if4.i_Enable               = tb_en && (sel == 0);
    assign if4.i_Fifo_Byte            = fifo_byte;
    assign if4.i_Fifo_Ready_To_Read   = fifo_ready;
    assign if2.i_Enable               = tb_en && (sel == 1);
    assign if2.i_Fifo_Byte            = fifo_byte;
    assign if2.i_Fifo_Ready_To_Read   = fifo_ready;
    assign if217.i_Enable             = tb_en && (sel == 2);
    assign if217.i_Fifo_Byte          = fifo_byte;
    assign if217.i_Fifo_Ready_To_Read = fifo_ready;

    uart_tx_drain #(.CLKS_PER_BIT(4))   u_dut4   (.i_Clk(clk), .i_Rst_L(rst_l), .bus(if4));
    uart_tx_drain #(.CLKS_PER_BIT(2))   u_dut2   (.i_Clk(clk), .i_Rst_L(rst_l), .bus(if2));
    uart_tx_drain #(.CLKS_PER_BIT(217)) u_dut217 (.i_Clk(clk), .i_Rst_L(rst_l), .bus(if217));

    logic mon_serial, mon_shift, mon_active, mon_done;
    assign mon_serial = (sel == 0) ? if4.o_Tx_Serial  : (sel == 1) ? if2.o_Tx_Serial  : if217.o_Tx_Serial;
    assign mon_shift  = (sel == 0) ? if4.o_Fifo_Shift : (sel == 1) ? if2.o_Fifo_Shift : if217.o_Fifo_Shift;
    assign mon_active = (sel == 0) ? if4.o_Tx_Active  : (sel == 1) ? if2.o_Tx_Active  : if217.o_Tx_Active;
    assign mon_done   = (sel == 0) ? if4.o_Tx_Done    : (sel == 1) ? if2.o_Tx_Done    : if217.o_Tx_Done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   shift_count;
    logic pop_pending;
    logic s_serial, s_shift, s_active, s_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] w(input logic x);
        return {31'd0, x};
    endfunction

    // Expected line level t cycles after the accepting edge: start, 8 data LSB first, stop.
    function automatic logic exp_line(input int t, input int cpb, input logic [7:0] b);
        int k;
        k = t / cpb;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic refresh_fifo();
        fifo_ready = (fifo_q.size() != 0);
        fifo_byte  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh_fifo();
    endtask

    // Advance one clock; FIFO model pops on the edge after a shift pulse.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh_fifo();
        s_serial = mon_serial;
        s_shift  = mon_shift;
        s_active = mon_active;
        s_done   = mon_done;
        pop_pending = s_shift;
        if (s_shift) shift_count++;
        cyc++;
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            check_eq({tag, "_shift"},  w(s_shift),  32'd0);
            check_eq({tag, "_line"},   w(s_serial), 32'd1);
            check_eq({tag, "_active"}, w(s_active), 32'd0);
        end
    endtask

    task automatic expect_frame(input string tag, input int cpb, input logic [7:0] b,
                                input int max_wait, input int drop_at, output int e0);
        logic found;
        found = 1'b0;
        e0 = -1;
        for (int i = 0; i < max_wait; i++) begin
            cycle();
            if (s_shift) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check_eq({tag, "_start_timeout"}, 32'd0, 32'd1);
            return;
        end
        e0 = cyc;
        for (int t = 0; t <= 10 * cpb; t++) begin
            if (t > 0) cycle();
            if (t == drop_at) tb_en = 1'b0;
            check_eq({tag, "_line"},   w(s_serial), w((t < 10 * cpb) ? exp_line(t, cpb, b) : 1'b1));
            check_eq({tag, "_shift"},  w(s_shift),  w(t == 0));
            check_eq({tag, "_active"}, w(s_active), w(t < 10 * cpb));
            check_eq({tag, "_done"},   w(s_done),   w(t == 10 * cpb));
        end
    endtask

    int         e0, e0a, e0b, e0c, prev_e0, wait_n, drop, n, sc0;
    logic [7:0] b, b1, b2;
    logic [7:0] exp_q[$];
    logic       found;

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0; shift_count = 0;
        pop_pending = 1'b0;
        sel = 0; tb_en = 1'b0; rst_l = 1'b0;
        refresh_fifo();
        repeat (3) cycle();

        check_eq("rst_line4",   w(if4.o_Tx_Serial),    32'd1);
        check_eq("rst_shift4",  w(if4.o_Fifo_Shift),   32'd0);
        check_eq("rst_active4", w(if4.o_Tx_Active),    32'd0);
        check_eq("rst_done4",   w(if4.o_Tx_Done),      32'd0);
        check_eq("rst_line2",   w(if2.o_Tx_Serial),    32'd1);
        check_eq("rst_line217", w(if217.o_Tx_Serial),  32'd1);
        check_eq("rst_act217",  w(if217.o_Tx_Active),  32'd0);
        rst_l = 1'b1;
        cycle();

        // Single byte
        push(8'hA5);
        tb_en = 1'b1;
        expect_frame("single", 4, 8'hA5, 3, -1, e0);
        expect_idle("single_after", 5);

        // Back-to-back
        tb_en = 1'b0;
        sc0 = shift_count;
        push(8'h00); push(8'hFF); push(8'h3C);
        tb_en = 1'b1;
        expect_frame("b2b0", 4, 8'h00, 3, -1, e0a);
        expect_frame("b2b1", 4, 8'hFF, 1, -1, e0b);
        expect_frame("b2b2", 4, 8'h3C, 1, -1, e0c);
        check_eq("b2b_gap01", 32'(e0b - e0a), 32'd41);
        check_eq("b2b_gap12", 32'(e0c - e0b), 32'd41);
        expect_idle("b2b_after", 20);
        check_eq("b2b_shifts", 32'(shift_count - sc0), 32'd3);
        check_eq("b2b_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // Empty, then disabled
        expect_idle("empty", 100);
        tb_en = 1'b0;
        push(8'h5A);
        expect_idle("disabled", 100);
        tb_en = 1'b1;
        expect_frame("enable_rise", 4, 8'h5A, 1, -1, e0);

        // Enable drop mid-frame
        push(8'hC3); push(8'h96);
        expect_frame("drop", 4, 8'hC3, 2, 22, e0);
        expect_idle("drop_hold", 30);
        tb_en = 1'b1;
        expect_frame("drop_resume", 4, 8'h96, 1, -1, e0);

        // Reset during data bit 3
        tb_en = 1'b0;
        expect_idle("pre_rst", 3);
        b1 = 8'h6B; b2 = 8'hD4;
        push(b1); push(b2);
        tb_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (s_shift) begin found = 1'b1; break; end
        end
        check_eq("rst_mid_start", w(found), 32'd1);
        for (int k = 1; k <= 17; k++) cycle();
        check_eq("rst_mid_bit3", w(s_serial), w(b1[3]));
        rst_l = 1'b0;
        cycle();
        check_eq("rst_mid_line",   w(s_serial), 32'd1);
        check_eq("rst_mid_active", w(s_active), 32'd0);
        check_eq("rst_mid_done",   w(s_done),   32'd0);
        check_eq("rst_mid_shift",  w(s_shift),  32'd0);
        rst_l = 1'b1;
        expect_frame("rst_next", 4, b2, 2, -1, e0);

        // Randomized frames with random enable drops
        tb_en = 1'b0;
        expect_idle("rand_pre", 2);
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 4);
            exp_q.delete();
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                push(b);
                exp_q.push_back(b);
            end
            tb_en = 1'b1;
            prev_e0 = -1;
            wait_n = 2;
            while (exp_q.size() != 0) begin
                drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 39)) : -1;
                b = exp_q.pop_front();
                expect_frame("rand", 4, b, wait_n, drop, e0);
                if (prev_e0 >= 0) check_eq("rand_gap", 32'(e0 - prev_e0), 32'd41);
                prev_e0 = e0;
                wait_n = 1;
                if (!tb_en) begin
                    expect_idle("rand_hold", $urandom_range(1, 6));
                    tb_en = 1'b1;
                    prev_e0 = -1;
                end
            end
            tb_en = 1'b0;
            expect_idle("rand_gap_idle", $urandom_range(1, 5));
        end

        // Parameter sweep
        sel = 1;
        push(8'h81);
        tb_en = 1'b1;
        expect_frame("cpb2", 2, 8'h81, 3, -1, e0);
        tb_en = 1'b0;
        expect_idle("cpb2_after", 3);
        sel = 2;
        push(8'h81);
        tb_en = 1'b1;
        expect_frame("cpb217", 217, 8'h81, 3, -1, e0);
        tb_en = 1'b0;
        expect_idle("cpb217_after", 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Downstream consumer of the 8-entry UART stream buffer FIFO. Whenever the FIFO reports data and the block is enabled and idle, it takes the head byte, pops it with a one-cycle shift pulse, and serialises it as a UART 8N1 frame. It sits between the stream buffer and the board's TX pin, and provides frame-level active and done status.

## Interface
Parameters:
- CLKS_PER_BIT, 217 — clock cycles per UART bit. 217 gives 115200 baud at 25 MHz. Legal range is 2 to 65535.

Ports:
- i_Clk  input  1  — system clock; all logic is on the rising edge.
- i_Rst_L  input  1  — reset, synchronous, active-low.
- i_Enable  input  1  — permits starting a new frame; sampled only in IDLE.
- i_Fifo_Byte  input  8  — FIFO head byte; valid whenever i_Fifo_Ready_To_Read=1.
- i_Fifo_Ready_To_Read  input  1  — FIFO holds at least one byte.
- o_Fifo_Shift  output  1  — one-cycle pop pulse to the FIFO.
- o_Tx_Serial  output  1  — UART line; idles high.
- o_Tx_Active  output  1  — high while a frame is on the line.
- o_Tx_Done  output  1  — one-cycle pulse after the stop bit completes.

## Operation
- All outputs are registered.
- Reset values: o_Tx_Serial=1, o_Fifo_Shift=0, o_Tx_Active=0, o_Tx_Done=0. State=IDLE, counters=0, shift register=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Condition to leave: i_Enable=1 and i_Fifo_Ready_To_Read=1 at an edge.
  - On that edge: latch i_Fifo_Byte into the shift register; o_Fifo_Shift<=1; o_Tx_Serial<=0; o_Tx_Active<=1; bit-clock counter<=0; go to START.
- START: drive the line low for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - Drive bits 0..7, LSB first, each held for CLKS_PER_BIT cycles.
  - Bit index is 3 bits. After bit 7, go to STOP.
- STOP: drive the line high for CLKS_PER_BIT cycles. At expiry:
  - o_Tx_Done<=1 for exactly one cycle;
  - o_Tx_Active<=0;
  - return to IDLE.
- o_Fifo_Shift is high for exactly one cycle per frame. It must never assert outside the IDLE->START transition.
- The bit-clock counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Enable gating:
  - i_Enable and i_Fifo_Ready_To_Read are ignored outside IDLE.
  - Dropping i_Enable mid-frame does not abort the frame.
  - Ready dropping mid-frame has no effect.
- Sampling rule: the FIFO's ready and head byte update one edge after the shift. The block cannot re-sample them early because a frame lasts at least 20 cycles.
- Reset mid-frame: at the reset edge, all state returns to reset values and the line goes high immediately. The popped byte is lost; no extra shift is issued.

## Timing
- Let E0 be the edge where IDLE accepts a byte.
- o_Fifo_Shift is high between E0 and E0+1. The FIFO pops at edge E0+1.
- Start bit: line low from E0 to E0+CLKS_PER_BIT.
- Data bit i (0..7): line holds it from E0+(1+i)·CLKS_PER_BIT to E0+(2+i)·CLKS_PER_BIT.
- Stop bit: line high from E0+9·CLKS_PER_BIT to E0+10·CLKS_PER_BIT.
- At E0+10·CLKS_PER_BIT: o_Tx_Done is high for one cycle and o_Tx_Active falls.
- Earliest next acceptance is edge E0+10·CLKS_PER_BIT+1.
  - Back-to-back frame period is 10·CLKS_PER_BIT+1 cycles.
  - The extra idle-high cycle between frames is the minimum gap.
- o_Tx_Active is high from E0 to E0+10·CLKS_PER_BIT, i.e. exactly 10·CLKS_PER_BIT cycles.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, FIFO model holds 0xA5, enable=1.
  - Line pattern is 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles.
  - One shift pulse at E0.
  - Done at E0+40; active high for 40 cycles.
- **Back-to-back:** FIFO preloaded with 0x00, 0xFF, 0x3C.
  - Three frames, with starts 41 cycles apart.
  - Exactly 3 shift pulses.
  - The FIFO empties, and the line stays high afterwards.
- **Empty or disabled:**
  - Ready=0 for 100 cycles, then ready=1 with enable=0 for 100 cycles: no shift, line=1, active=0.
  - Raise enable: a frame starts on the next edge.
- **Enable drop mid-frame:** deassert enable during DATA. The frame completes with the correct bits and Done; no new frame starts while enable=0.
- **Reset mid-frame:** assert i_Rst_L=0 for 1 cycle during bit 3.
  - Next cycle: line=1, active=0, done=0, shift=0.
  - Next FIFO byte transmits in full after release.
- **Parameter sweep:** CLKS_PER_BIT=2 and 217 with byte 0x81. Each bit's width measures exactly CLKS_PER_BIT cycles on the line.
